aes_cipher_drain: RTL and testbench

//  Downstream drain stage for the buffered AES wrapper's ciphertext ring. Pops 128-bit entries
//  (buffer_val/buffer_data/buffer_pop) and writes each as two 64-bit beats to a valid/ready memory

---
 rtl/aes_cipher_drain_if.sv | 31 +++
 rtl/aes_cipher_drain.sv | 178 +++++++++++++++++
 tb/tb_aes_cipher_drain.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_cipher_drain_if.sv
// rtl/aes_cipher_drain_if.sv - config, ciphertext-buffer and memory-request signal bundle for the drain
// Ports: cfg_* config access and read response, buffer_* ring head handshake, mem_req_* write beats,
// done_pulse run completion. slave = drain view, master = driver/memory view.
interface aes_cipher_drain_if #(
    parameter int ADDR_WIDTH = 40
);
    logic                  cfg_hsk;
    logic [15:0]           cfg_addr;
    logic [63:0]           cfg_data;
    logic                  cfg_load;
    logic                  cfg_rvalid;
    logic [63:0]           cfg_rdata;
    logic                  buffer_val;
    logic [127:0]          buffer_data;
    logic                  buffer_pop;
    logic                  mem_req_val;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [63:0]           mem_req_data;
    logic                  mem_req_rdy;
    logic                  done_pulse;

    modport slave (
        input  cfg_hsk, cfg_addr, cfg_data, cfg_load, buffer_val, buffer_data, mem_req_rdy,
        output cfg_rvalid, cfg_rdata, buffer_pop, mem_req_val, mem_req_addr, mem_req_data, done_pulse
    );

    modport master (
        output cfg_hsk, cfg_addr, cfg_data, cfg_load, buffer_val, buffer_data, mem_req_rdy,
        input  cfg_rvalid, cfg_rdata, buffer_pop, mem_req_val, mem_req_addr, mem_req_data, done_pulse
    );
endinterface

// File: rtl/aes_cipher_drain.sv
// rtl/aes_cipher_drain.sv - drains 128-bit ciphertext entries to memory as two 64-bit beats
// Ports: clk, rst_n (async active-low), bus (aes_cipher_drain_if.slave: config, buffer, memory, done).
// Optional feature: define AES_DRAIN_STALL_CNT_EN for a saturating 32-bit stall counter read at 0x00C0.
module aes_cipher_drain #(
    parameter int ADDR_WIDTH = 40,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_cipher_drain_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HI, S_LO} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0]  drained_q, drained_d;
    logic [127:0]          hold_q, hold_d;
    logic                  err_q, err_d;
    logic                  abort_q, abort_d;
    logic                  done_q, done_d;
    logic                  rvalid_q, rvalid_d;
    logic [63:0]           rdata_q, rdata_d;

    logic                  wr, rd, wr_base, wr_cnt, wr_abort, busy;
    logic                  pop, run_start, mem_val;
    logic [CNT_WIDTH-1:0]  cnt_val;
    logic [63:0]           stall_word;

    assign wr       = bus.cfg_hsk && !bus.cfg_load;
    assign rd       = bus.cfg_hsk && bus.cfg_load;
    assign wr_base  = wr && (bus.cfg_addr == 16'h0080);
    assign wr_cnt   = wr && (bus.cfg_addr == 16'h0090);
    assign wr_abort = wr && (bus.cfg_addr == 16'h00A0);
    assign cnt_val  = bus.cfg_data[CNT_WIDTH-1:0];
    assign busy     = (state_q != S_IDLE);
    assign mem_val  = (state_q == S_HI) || (state_q == S_LO);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        drained_d   = drained_q;
        hold_d      = hold_q;
        err_d       = err_q;
        abort_d     = abort_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        run_start   = 1'b0;

        if (rd && bus.cfg_addr == 16'h00A0) err_d = 1'b0;
        if (wr_cnt && busy)                 err_d = 1'b1;
        if (wr_base && !busy)               base_d = {bus.cfg_data[ADDR_WIDTH-1:4], 4'b0000};

        case (state_q)
            S_IDLE: begin
                if (wr_cnt) begin
                    if (cnt_val == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = S_WAIT;
                        addr_d      = base_q;
                        drained_d   = '0;
                        remaining_d = cnt_val;
                        abort_d     = 1'b0;
                        run_start   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Abort wins over a waiting entry so nothing is popped that will not be written.
                if (wr_abort) begin
                    state_d = S_IDLE;
                end else if (bus.buffer_val) begin
                    pop     = 1'b1;
                    hold_d  = bus.buffer_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (wr_abort) abort_d = 1'b1;
                if (bus.mem_req_rdy) state_d = S_LO;
            end
            S_LO: begin
                if (wr_abort) abort_d = 1'b1;
                if (bus.mem_req_rdy) begin
                    addr_d = addr_q + ADDR_WIDTH'(16);
                    if (drained_q != '1)   drained_d   = drained_q + 1'b1;
                    if (remaining_q != '0) remaining_d = remaining_q - 1'b1;
                    // An abort raised during the block (or on its last beat) ends the run quietly.
                    if (abort_q || wr_abort) begin
                        state_d = S_IDLE;
                    end else if (remaining_q <= CNT_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rvalid_d = rd;
        rdata_d  = '0;
        if (rd) begin
            case (bus.cfg_addr)
                16'h00A0: rdata_d = {err_q, busy, {(62-CNT_WIDTH){1'b0}}, drained_q};
                16'h00C0: rdata_d = stall_word;
                default:  rdata_d = '0;
            endcase
        end
    end

`ifdef AES_DRAIN_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (run_start)
            stall_d = '0;
        else if (mem_val && !bus.mem_req_rdy && stall_q != '1)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_word = {32'b0, stall_q};
`else
    logic unused_run_start;
    assign unused_run_start = run_start;
    assign stall_word       = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            drained_q   <= '0;
            hold_q      <= '0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            done_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            drained_q   <= drained_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
            done_q      <= done_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    logic unused_cfg_bits;
    assign unused_cfg_bits = ^bus.cfg_data[63:ADDR_WIDTH];

    assign bus.buffer_pop   = pop;
    assign bus.mem_req_val  = mem_val;
    assign bus.mem_req_addr = (state_q == S_LO) ? addr_q + ADDR_WIDTH'(8) : addr_q;
    assign bus.mem_req_data = (state_q == S_HI) ? hold_q[127:64] : hold_q[63:0];
    assign bus.done_pulse   = done_q;
    assign bus.cfg_rvalid   = rvalid_q;
    assign bus.cfg_rdata    = rdata_q;
endmodule

// File: tb/tb_aes_cipher_drain.sv
// tb/tb_aes_cipher_drain.sv - randomized self-checking bench for aes_cipher_drain
module tb_aes_cipher_drain;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_cipher_drain_if #(.ADDR_WIDTH(40)) bus ();
    aes_cipher_drain #(.ADDR_WIDTH(40), .CNT_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    logic [127:0] bq[$];
    logic [127:0] sent[$];
    logic [39:0]  obs_addr[$];
    logic [63:0]  obs_data[$];
    int pops = 0, dones = 0, stab_err = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    int buf_mode = 0;   // 0: head valid whenever queued, 1: randomly withheld
    logic         prev_stall = 1'b0;
    logic [39:0]  prev_addr;
    logic [63:0]  prev_data;

    // Buffer / memory model: samples at negedge, drives 2 time units after posedge.
    initial begin
        bus.buffer_val = 1'b0; bus.buffer_data = '0; bus.mem_req_rdy = 1'b0;
        forever begin
            logic pop_now;
            @(negedge clk);
            pop_now = 1'b0;
            if (rst_n) begin
                if (bus.mem_req_val && bus.mem_req_rdy) begin
                    obs_addr.push_back(bus.mem_req_addr);
                    obs_data.push_back(bus.mem_req_data);
                end
                if (bus.buffer_pop) begin pops++; pop_now = 1'b1; end
                if (bus.done_pulse) dones++;
                if (prev_stall && (!bus.mem_req_val || bus.mem_req_addr !== prev_addr ||
                                   bus.mem_req_data !== prev_data)) stab_err++;
                prev_stall = bus.mem_req_val && !bus.mem_req_rdy;
                prev_addr  = bus.mem_req_addr;
                prev_data  = bus.mem_req_data;
            end
            @(posedge clk); #2;
            if (pop_now && bq.size() > 0) void'(bq.pop_front());
            bus.buffer_val  = (bq.size() > 0) && (buf_mode == 0 || $urandom_range(0, 3) != 0);
            bus.buffer_data = (bq.size() > 0) ? bq[0] : '0;
            bus.mem_req_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cfg_write(input logic [15:0] a, input logic [63:0] d);
        bus.cfg_hsk = 1'b1; bus.cfg_load = 1'b0; bus.cfg_addr = a; bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_hsk = 1'b0;
    endtask

    task automatic cfg_read(input logic [15:0] a, output logic [63:0] d, output logic ok);
        bus.cfg_hsk = 1'b1; bus.cfg_load = 1'b1; bus.cfg_addr = a;
        @(posedge clk); #1;
        bus.cfg_hsk = 1'b0; bus.cfg_load = 1'b0;
        ok = bus.cfg_rvalid;
        d  = bus.cfg_rdata;
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); sent.delete();
        pops = 0; dones = 0; stab_err = 0;
    endtask

    task automatic push_entries(input int n);
        for (int i = 0; i < n; i++) begin
            logic [127:0] e;
            e = {$urandom, $urandom, $urandom, $urandom};
            bq.push_back(e);
            sent.push_back(e);
        end
    endtask

    task automatic wait_done(input int bound, output logic ok);
        int start;
        start = dones;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (dones > start) begin ok = 1'b1; break; end
        end
    endtask

    // Expected write stream: block i goes to base+16*i (HI half) and base+16*i+8 (LO half), mod 2^40.
    function automatic int beats_bad(input logic [39:0] base, input int n);
        int bad;
        logic [39:0] a;
        bad = 0;
        if (obs_addr.size() != 2 * n) return 1000 + obs_addr.size();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 2; j++) begin
                a = (base & ~40'hF) + 40'(16 * i + 8 * j);
                if (obs_addr[2*i+j] !== a) bad++;
                if (obs_data[2*i+j] !== (j == 0 ? sent[i][127:64] : sent[i][63:0])) bad++;
            end
        end
        return bad;
    endfunction

    task automatic test_reset();
        logic [63:0] d;
        logic ok;
        n_assert++;
        if ({bus.mem_req_val, bus.buffer_pop, bus.done_pulse, bus.cfg_rvalid} !== 4'b0 ||
            bus.mem_req_addr !== '0 || bus.mem_req_data !== '0 || bus.cfg_rdata !== '0) begin
            n_fail++; $display("FAIL reset_outputs: val/pop/done/rvalid=%b addr=%h", 
                {bus.mem_req_val, bus.buffer_pop, bus.done_pulse, bus.cfg_rvalid}, bus.mem_req_addr);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cfg_read(16'h00A0, d, ok);
        n_assert++;
        if (!ok || d !== 64'h0) begin n_fail++; $display("FAIL reset_status: rvalid=%b got %h want 0", ok, d); end
        n_assert++;
        @(posedge clk); #1;
        if (bus.cfg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_one_cycle: got %b want 0", bus.cfg_rvalid); end
        cfg_read(16'h00C0, d, ok);
        n_assert++;
        if (!ok || d !== 64'h0) begin n_fail++; $display("FAIL reset_stall: got %h want 0", d); end
        cfg_write(16'h0090, 64'h0);
        cfg_read(16'h0010, d, ok);
        n_assert++;
        if (!ok || d !== 64'h0) begin n_fail++; $display("FAIL other_read: got %h want 0", d); end
    endtask

    task automatic test_basic();
        logic [63:0] d;
        logic ok;
        clear_obs(); rdy_mode = 0; buf_mode = 0;
        push_entries(2);
        cfg_write(16'h0080, 64'h1000);
        cfg_write(16'h0090, 64'd2);
        wait_done(100, ok);
        repeat (3) @(posedge clk); #1;
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: no done_pulse within 100 cycles"); end
        n_assert++;
        if (beats_bad(40'h1000, 2) !== 0) begin n_fail++; $display("FAIL basic_beats: %0d bad, want 0", beats_bad(40'h1000, 2)); end
        n_assert++;
        if (pops !== 2 || dones !== 1) begin n_fail++; $display("FAIL basic_counts: pops=%0d dones=%0d want 2/1", pops, dones); end
        cfg_read(16'h00A0, d, ok);
        n_assert++;
        if (d !== 64'd2) begin n_fail++; $display("FAIL basic_status: got %h want 2", d); end
    endtask

    task automatic test_stall();
        logic [63:0] d, want;
        logic ok, seen;
        logic [127:0] e;
        clear_obs(); rdy_mode = 2; buf_mode = 0;
        e = 128'h0123456789ABCDEF0123456789ABCDEF;
        bq.push_back(e); sent.push_back(e);
        cfg_write(16'h0080, 64'h2000);
        cfg_write(16'h0090, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.mem_req_val) begin seen = 1'b1; break; end
        end
        n_assert++;
        if (!seen) begin n_fail++; $display("FAIL stall_first_beat: mem_req_val never rose"); end
        for (int i = 0; i < 5; i++) begin
            n_assert++;
            if (!bus.mem_req_val || bus.mem_req_addr !== 40'h2000 || bus.mem_req_data !== e[127:64]) begin
                n_fail++; $display("FAIL stall_hold[%0d]: val=%b addr=%h data=%h want 1/2000/%h", i,
                    bus.mem_req_val, bus.mem_req_addr, bus.mem_req_data, e[127:64]);
            end
            @(posedge clk); #1;
        end
        rdy_mode = 0;
        wait_done(50, ok);
        n_assert++;
        if (!ok || beats_bad(40'h2000, 1) !== 0 || stab_err !== 0) begin
            n_fail++; $display("FAIL stall_result: done=%b bad=%0d stab=%0d want 1/0/0", ok, beats_bad(40'h2000, 1), stab_err);
        end
`ifdef AES_DRAIN_STALL_CNT_EN
        want = 64'd5;
`else
        want = 64'd0;
`endif
        cfg_read(16'h00C0, d, ok);
        n_assert++;
        if (d !== want) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", d, want); end
    endtask

    task automatic test_wait_hold();
        logic [63:0] d;
        logic ok, quiet;
        clear_obs(); rdy_mode = 0; buf_mode = 0;
        cfg_write(16'h0080, 64'h3000);
        cfg_write(16'h0090, 64'd3);
        quiet = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.mem_req_val || bus.buffer_pop) quiet = 1'b0;
        end
        n_assert++;
        if (!quiet) begin n_fail++; $display("FAIL wait_quiet: traffic while buffer empty"); end
        cfg_read(16'h00A0, d, ok);
        n_assert++;
        if (d[63:62] !== 2'b01) begin n_fail++; $display("FAIL wait_busy: err/busy=%b want 01", d[63:62]); end
        push_entries(3);
        wait_done(100, ok);
        n_assert++;
        if (!ok || beats_bad(40'h3000, 3) !== 0 || pops !== 3) begin
            n_fail++; $display("FAIL wait_resume: done=%b bad=%0d pops=%0d want 1/0/3", ok, beats_bad(40'h3000, 3), pops);
        end
    endtask

    task automatic test_wrap();
        logic ok;
        clear_obs(); rdy_mode = 0; buf_mode = 0;
        push_entries(2);
        cfg_write(16'h0080, 64'hFF_FFFF_FFF0);
        cfg_write(16'h0090, 64'd2);
        wait_done(100, ok);
        n_assert++;
        if (!ok || beats_bad(40'hFF_FFFF_FFF0, 2) !== 0) begin
            n_fail++; $display("FAIL wrap_beats: done=%b bad=%0d want 1/0", ok, beats_bad(40'hFF_FFFF_FFF0, 2));
        end
        n_assert++;
        if (obs_addr.size() != 4 || obs_addr[2] !== 40'h0 || obs_addr[3] !== 40'h8) begin
            n_fail++; $display("FAIL wrap_addr: n=%0d want 4 beats with block 2 at 0x0/0x8", obs_addr.size());
        end
    endtask

    task automatic test_abort();
        logic [63:0] d;
        logic ok, seen;
        clear_obs(); rdy_mode = 2; buf_mode = 0;
        push_entries(3);
        cfg_write(16'h0080, 64'h4000);
        cfg_write(16'h0090, 64'd3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.mem_req_val) begin seen = 1'b1; break; end
        end
        rdy_mode = 0;
        cfg_write(16'h00A0, 64'h0);
        repeat (20) @(posedge clk); #1;
        n_assert++;
        if (!seen || beats_bad(40'h4000, 1) !== 0 || pops !== 1 || dones !== 0) begin
            n_fail++; $display("FAIL abort_hi: seen=%b bad=%0d pops=%0d dones=%0d want 1/0/1/0",
                seen, beats_bad(40'h4000, 1), pops, dones);
        end
        cfg_read(16'h00A0, d, ok);
        n_assert++;
        if (d !== 64'd1) begin n_fail++; $display("FAIL abort_hi_status: got %h want 1", d); end
        bq.delete();
        clear_obs();
        cfg_write(16'h0090, 64'd2);
        repeat (3) @(posedge clk); #1;
        cfg_write(16'h00A0, 64'h0);
        cfg_read(16'h00A0, d, ok);
        n_assert++;
        if (d[62] !== 1'b0 || pops !== 0 || dones !== 0 || obs_addr.size() != 0) begin
            n_fail++; $display("FAIL abort_wait: busy=%b pops=%0d dones=%0d beats=%0d want all 0",
                d[62], pops, dones, obs_addr.size());
        end
    endtask

    task automatic test_err_and_zero();
        logic [63:0] d;
        logic ok;
        clear_obs(); rdy_mode = 0; buf_mode = 0;
        cfg_write(16'h0090, 64'd2);
        cfg_write(16'h0090, 64'd5);
        cfg_read(16'h00A0, d, ok);
        n_assert++;
        if (d !== 64'hC000_0000_0000_0000) begin n_fail++; $display("FAIL err_set: got %h want c000000000000000", d); end
        cfg_read(16'h00A0, d, ok);
        n_assert++;
        if (d !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL err_clear: got %h want 4000000000000000", d); end
        cfg_write(16'h00A0, 64'h0);
        repeat (2) @(posedge clk); #1;
        clear_obs();
        cfg_write(16'h0090, 64'd0);
        repeat (4) @(posedge clk); #1;
        n_assert++;
        if (dones !== 1 || pops !== 0 || obs_addr.size() != 0) begin
            n_fail++; $display("FAIL zero_count: dones=%0d pops=%0d beats=%0d want 1/0/0", dones, pops, obs_addr.size());
        end
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [39:0] base;
        logic ok;
        int n;
        for (int r = 0; r < 6; r++) begin
            clear_obs(); rdy_mode = 1; buf_mode = 1;
            n = $urandom_range(1, 6);
            base = {8'($urandom), 32'($urandom)};
            push_entries(n);
            cfg_write(16'h0080, {24'h0, base});
            cfg_write(16'h0090, 64'(n));
            wait_done(500, ok);
            repeat (2) @(posedge clk); #1;
            n_assert++;
            if (!ok || beats_bad(base, n) !== 0 || pops !== n || dones !== 1 || stab_err !== 0) begin
                n_fail++; $display("FAIL random[%0d]: done=%b bad=%0d pops=%0d dones=%0d stab=%0d n=%0d",
                    r, ok, beats_bad(base, n), pops, dones, stab_err, n);
            end
            cfg_read(16'h00A0, d, ok);
            n_assert++;
            if (d !== 64'(n)) begin n_fail++; $display("FAIL random_status[%0d]: got %h want %0d", r, d, n); end
        end
    endtask

    initial begin
        bus.cfg_hsk = 1'b0; bus.cfg_load = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_wait_hold();
        test_wrap();
        test_abort();
        test_err_and_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
